// File: rtl/pipelined_prefix_adder.sv
// Three-stage registered Kogge-Stone adder with valid/ready handshake.
// S1: generate/propagate, S2: first half of prefix levels, S3: remaining levels plus sum.
module pipelined_prefix_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int L  = $clog2(WIDTH);
    localparam int L1 = (L + 1) / 2;

    logic             adv;
    logic             s1_valid_reg, s2_valid_reg, s3_valid_reg;
    logic [WIDTH-1:0] s1_g_reg, s1_p_reg, s1_praw_reg;
    logic [WIDTH-1:0] s2_g_reg, s2_p_reg, s2_praw_reg;
    logic             s1_cin_reg, s2_cin_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg, ovf_reg;

    logic [WIDTH-1:0] g_pre, p_pre;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_next;
    logic             unused_p;

    // Whole pipeline moves as one; a stalled output freezes every stage.
    assign adv      = ~s3_valid_reg | out_ready;
    assign in_ready = adv;

    // cin is folded into bit 0 so column 0 already holds its final carry.
    assign g_pre = {a[WIDTH-1:1] & b[WIDTH-1:1], (a[0] & b[0]) | ((a[0] ^ b[0]) & cin)};
    assign p_pre = {a[WIDTH-1:1] ^ b[WIDTH-1:1], 1'b0};

    genvar gi, gj;
    generate
        for (gi = 0; gi <= L; gi++) begin : lvl
            logic [WIDTH-1:0] g_o, p_o;
            if (gi == 0) begin : src
                assign g_o = s1_g_reg;
                assign p_o = s1_p_reg;
            end else begin : node
                localparam int D = 2 ** (gi - 1);
                logic [WIDTH-1:0] lg, lp;
                if (gi == L1 + 1) begin : from_reg
                    assign lg = s2_g_reg;
                    assign lp = s2_p_reg;
                end else begin : from_comb
                    assign lg = lvl[gi-1].g_o;
                    assign lp = lvl[gi-1].p_o;
                end
                for (gj = 0; gj < WIDTH; gj++) begin : col
                    if (gj >= D) begin : big_circle
                        assign g_o[gj] = lg[gj] | (lp[gj] & lg[gj-D]);
                        assign p_o[gj] = lp[gj] & lp[gj-D];
                    end else begin : small_circle
                        assign g_o[gj] = lg[gj];
                        assign p_o[gj] = lp[gj];
                    end
                end
            end
        end
    endgenerate

    // After the last level every group reaches column 0, so G is the carry out of each bit.
    assign carry    = lvl[L].g_o;
    assign sum_next = s2_praw_reg ^ {carry[WIDTH-2:0], s2_cin_reg};
    assign unused_p = ^lvl[L].p_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s3_valid_reg <= 1'b0;
        end else if (adv) begin
            s1_valid_reg <= in_valid;
            s2_valid_reg <= s1_valid_reg;
            s3_valid_reg <= s2_valid_reg;
        end
    end

    // Data follows valid without reset; output gating hides stale contents.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_g_reg    <= g_pre;
            s1_p_reg    <= p_pre;
            s1_praw_reg <= a ^ b;
            s1_cin_reg  <= cin;
            s2_g_reg    <= lvl[L1].g_o;
            s2_p_reg    <= lvl[L1].p_o;
            s2_praw_reg <= s1_praw_reg;
            s2_cin_reg  <= s1_cin_reg;
            sum_reg     <= sum_next;
            cout_reg    <= carry[WIDTH-1];
            ovf_reg     <= carry[WIDTH-2] ^ carry[WIDTH-1];
        end
    end

    assign out_valid = s3_valid_reg;
    assign sum       = s3_valid_reg ? sum_reg : '0;
    assign cout      = s3_valid_reg & cout_reg;
    assign ovf       = s3_valid_reg & ovf_reg;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed and random bench for pipelined_prefix_adder (WIDTH=16) with a result scoreboard.
module tb_pipelined_prefix_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout, ovf;

    int checks   = 0;
    int failures = 0;

    logic [17:0] sbq[$];
    logic        prev_stall = 1'b0;
    logic [17:0] prev_out   = '0;

    logic [15:0] st_a   [4] = '{16'h0001, 16'h00FF, 16'hFFFE, 16'h8000};
    logic [15:0] st_b   [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h7FFF};
    logic [15:0] st_exp [4] = '{16'h0002, 16'h0100, 16'hFFFF, 16'hFFFF};

    pipelined_prefix_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain integer addition and the sign rule.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] t;
        logic        v;
        t = {1'b0, x} + {1'b0, y} + {16'd0, c};
        v = (x[15] == y[15]) && (t[15] != x[15]);
        return {v, t[16], t[15:0]};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, !out_valid || out_ready});
            if (prev_stall) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {14'd0, ovf, cout, sum}, {14'd0, prev_out});
            end
            if (!out_valid)
                chk("idle_zero", {14'd0, ovf, cout, sum}, 32'd0);
            if (out_valid && out_ready) begin
                chk("sb_nonempty", {31'd0, sbq.size() != 0}, 32'd1);
                if (sbq.size() != 0)
                    chk("sb_result", {14'd0, ovf, cout, sum}, {14'd0, sbq.pop_front()});
            end
            if (in_valid && in_ready)
                sbq.push_back(model(a, b, cin));
            prev_stall = out_valid && !out_ready;
            prev_out   = {ovf, cout, sum};
        end
    end

    task automatic send_beat(input logic [15:0] x, input logic [15:0] y, input logic c);
        bit acc;
        acc = 1'b0;
        a = x; b = y; cin = c; in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        chk("send_accepted", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] es, input logic ec, input logic eo);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
            chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
            chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        end
        @(posedge clk); #1;
    endtask

    // Latency counted in cycles from the cycle the beat is presented and accepted.
    task automatic send_timed(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c,
                              input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        a = x; b = y; cin = c; in_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 32'd3);
        chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_one_cycle"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int idx, got, accepted, cycles;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;

        // Reset held for two edges.
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_outputs", {14'd0, ovf, cout, sum}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        send_timed("single", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

        send_beat(16'hFFFF, 16'h0000, 1'b1);
        expect_out("carry_chain", 16'h0000, 1'b1, 1'b0);
        send_beat(16'h7FFF, 16'h0001, 1'b0);
        expect_out("pos_ovf", 16'h8000, 1'b0, 1'b1);
        send_beat(16'h8000, 16'h8000, 1'b0);
        expect_out("neg_ovf", 16'h0000, 1'b1, 1'b1);

        // Back-to-back stream with downstream stalled in cycles 4 and 5.
        idx = 0; got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            in_valid = (idx < 4);
            if (idx < 4) begin
                a = st_a[idx]; b = st_b[idx]; cin = 1'b0;
            end
            out_ready = !(c == 4 || c == 5);
            @(negedge clk);
            if (c == 4) chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                chk("stream_order", {16'd0, sum}, {16'd0, st_exp[got]});
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", got, 32'd4);
        repeat (4) begin @(posedge clk); #1; end

        // Two beats in flight, then a one-cycle reset.
        a = 16'h0101; b = 16'h0202; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'h0303; b = 16'h0404;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("flushed_no_output", {31'd0, out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        send_timed("post_reset", 16'h00F0, 16'h000F, 1'b1, 16'h0100, 1'b0, 1'b0);

        // Full-rate streaming with both handshakes held high.
        accepted = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            @(negedge clk);
            if (in_ready) accepted++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("throughput_accepts", accepted, 32'd20);
        repeat (5) begin @(posedge clk); #1; end

        // Random soak against the scoreboard.
        accepted = 0; cycles = 0;
        while (accepted < 10000 && cycles < 80000) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) accepted++;
            @(posedge clk); #1;
            cycles++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("soak_accepted", accepted, 32'd10000);
        repeat (10) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("soak_drained", sbq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_prefix_adder.md
Name: pipelined_prefix_adder

Overview:
- Registered, handshaked WIDTH-bit Kogge-Stone adder built around the team's prefix-cell library.
- Pipeline: generate/propagate pre-processing, a log2(WIDTH)-level prefix carry network of big_circle/small_circle cells, then sum post-processing.
- Cells are registered so the network closes timing at the core clock.
- Sits between the operand issue logic and the result writeback; it is the stage that feeds the small_circle cells and consumes their carries.

Parameters:
- WIDTH, 16, operand/sum width; power of two, 4..64.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- in_valid  input  1  operand beat present.
- in_ready  output  1  stage can accept an operand beat this cycle.
- a  input  WIDTH  operand A, unsigned/two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry in.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of MSB.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1 at an edge):
  - All stage valid bits clear; out_valid=0; sum=0; cout=0; ovf=0.
  - in_ready=1 from the first cycle after reset.
  - rst overrides every transfer in the same cycle; in-flight beats are discarded, never emitted.
- Pipeline, 3 register stages:
  - S1 registers bitwise g_i=a_i&b_i and p_i=a_i^b_i, plus p_raw for sum.
  - cin is folded into bit 0: G0 = g0 | p0&cin; P0 is forced to 0, so the bit-0 prefix node is a small_circle with C0 = G0.
  - S2 registers the outputs of prefix levels 1..ceil(L/2), where L = log2(WIDTH).
  - S3 registers the remaining levels plus sum_i = p_raw_i ^ C_(i-1), with C_(-1) = cin; cout = C_(WIDTH-1); ovf = C_(WIDTH-2) ^ C_(WIDTH-1).
  - big_circle cell: G = Gh | Ph&Gl, P = Ph&Pl. small_circle cell (leftmost column): C = G.
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k+3, assuming no stall.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - Global stall: adv = ~out_valid | out_ready.
  - When adv=1, all stages shift by one, with bubbles moving as invalid slots. When adv=0, all stage registers, including data, hold.
  - in_ready = adv (combinational from out_valid/out_ready only, never from in_valid).
  - When out_valid=1 and out_ready=0, sum/cout/ovf hold stable until accepted.
- Throughput: 1 beat/cycle when out_ready is held high. Order is strictly preserved; no drops, no duplicates.
- Bubbles are not collapsed while stalled; they do shift whenever adv=1.
- Data registers of invalid stages may update freely, but outputs must read 0 whenever out_valid=0 (sum/cout/ovf gated).
- Simultaneous in-accept and out-accept in the same cycle is legal and sustains full throughput.

Test Plan:
- Reset, WIDTH=16: hold rst 2 cycles -> out_valid=0, sum=0x0000, cout=0, ovf=0; in_ready=1 the cycle after rst drops.
- Single beat a=0x1234, b=0x4321, cin=0, out_ready=1 -> exactly 3 cycles later out_valid=1 for one cycle, sum=0x5555, cout=0, ovf=0.
- Full carry chain a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Back-to-back stream of 4 beats, (0x0001+0x0001), (0x00FF+0x0001), (0xFFFE+0x0001), (0x8000+0x7FFF), with out_ready=0 for cycles 4-5:
  - Results 0x0002, 0x0100, 0xFFFF, 0xFFFF arrive in order.
  - in_ready=0 exactly while out_valid=1 and out_ready=0.
  - The held result stays stable; no beat is lost or repeated.
- Reset mid-operation: 2 beats in flight, assert rst for 1 cycle -> out_valid=0 on the next cycle, neither result ever appears, and the next accepted beat has latency 3.
- Random soak: 10k beats with random in_valid/out_ready against a scoreboard computing {cout,sum} = a+b+cin and ovf -> zero mismatches; throughput 1/cycle when both signals are held high.
